// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its cache.
// Imported by the interface, the cache and the fetch top.
package if_fetch_pkg;

  typedef logic [31:0] addr_bus_t;
  typedef logic [31:0] inst_bus_t;
  typedef logic [7:0]  byte_bus_t;

  localparam logic      ENABLE    = 1'b1;
  localparam logic      DISABLE   = 1'b0;
  localparam addr_bus_t ZERO_WORD = 32'h0000_0000;

  localparam int ICACHE_LINES_DFLT = 64;
  localparam int ICACHE_IDX_W_DFLT = $clog2(ICACHE_LINES_DFLT);

  typedef enum logic {
    IF_IDLE  = 1'b0,
    IF_FETCH = 1'b1
  } if_state_e;

  function automatic addr_bus_t word_base(input addr_bus_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage (master) and the memory controller (slave).
// The controller acks in the same cycle it returns the byte.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic      mem_req;
  addr_bus_t mem_addr;
  logic      mem_ack;
  byte_bus_t mem_rdata;

  modport master (output mem_req, output mem_addr, input  mem_ack, input  mem_rdata);
  modport slave  (input  mem_req, input  mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, synchronous write, synchronous clear of the valid bits.
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter  int LINES = ICACHE_LINES_DFLT,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = 32 - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output inst_bus_t        rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  inst_bus_t        wr_data
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  inst_bus_t        data_q [LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone gate their use,
  // which keeps them mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: cache lookup on pc_i, four-byte refill on a miss,
// registered {pc, inst} towards IF/ID, stall request and jump abort.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = ICACHE_LINES_DFLT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  addr_bus_t pc_i,
  input  logic      jump_enable,
  input  logic      id_stall,
  if_fetch_if.master mem,
  output logic      stall_req,
  output logic      if_valid,
  output addr_bus_t if_pc,
  output inst_bus_t if_inst
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  if_state_e state_q,    state_d;
  logic [1:0] bcnt_q,    bcnt_d;
  logic      mem_req_q,  mem_req_d;
  addr_bus_t mem_addr_q, mem_addr_d;
  inst_bus_t inst_q,     inst_d;
  logic      if_valid_q, if_valid_d;
  addr_bus_t if_pc_q,    if_pc_d;
  inst_bus_t if_inst_q,  if_inst_d;

  logic      hit;
  inst_bus_t hit_data;
  logic      cache_we;
  logic      last_ack;
  inst_bus_t fill_word;
  logic      unused_pc_bits;

  assign unused_pc_bits = ^pc_i[1:0];

  // The refill address stays inside one word until the final ack, so its
  // upper bits double as the line's index and tag for the write-back.
  if_fetch_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc_i[IDX_W+1:2]),
    .rd_tag  (pc_i[31:IDX_W+2]),
    .rd_hit  (hit),
    .rd_data (hit_data),
    .wr_en   (cache_we && rdy && rst),
    .wr_idx  (mem_addr_q[IDX_W+1:2]),
    .wr_tag  (mem_addr_q[31:IDX_W+2]),
    .wr_data (fill_word)
  );

  assign last_ack  = (state_q == IF_FETCH) && mem.mem_ack && (bcnt_q == 2'd3);
  assign fill_word = {mem.mem_rdata, inst_q[23:0]};

  // NOTE: every always_comb output is given its hold value first, so no path
  // through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    inst_d     = inst_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    cache_we   = DISABLE;

    if (jump_enable) begin
      state_d   = IF_IDLE;
      bcnt_d    = 2'd0;
      mem_req_d = DISABLE;
      if (!id_stall) if_valid_d = DISABLE;
    end else begin
      unique case (state_q)
        IF_IDLE: begin
          if (hit) begin
            if (!id_stall) begin
              if_valid_d = ENABLE;
              if_pc_d    = pc_i;
              if_inst_d  = hit_data;
            end
          end else begin
            state_d    = IF_FETCH;
            bcnt_d     = 2'd0;
            mem_req_d  = ENABLE;
            mem_addr_d = word_base(pc_i);
          end
        end
        IF_FETCH: begin
          if (mem.mem_ack) begin
            inst_d[{bcnt_q, 3'b000} +: 8] = mem.mem_rdata;
            bcnt_d     = bcnt_q + 2'd1;
            mem_addr_d = mem_addr_q + 32'd1;
            if (bcnt_q == 2'd3) begin
              state_d   = IF_IDLE;
              mem_req_d = DISABLE;
              cache_we  = ENABLE;
              if (!id_stall) begin
                if_valid_d = ENABLE;
                if_pc_d    = word_base(mem_addr_q);
                if_inst_d  = fill_word;
              end
            end
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  // Reset wins over rdy; rdy=0 freezes every register.
  // NOTE: sequential state uses non-blocking assignment so all flops sample
  // their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IF_IDLE;
      bcnt_q     <= 2'd0;
      mem_req_q  <= DISABLE;
      mem_addr_q <= ZERO_WORD;
      inst_q     <= ZERO_WORD;
      if_valid_q <= DISABLE;
      if_pc_q    <= ZERO_WORD;
      if_inst_q  <= ZERO_WORD;
    end else if (rdy) begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      inst_q     <= inst_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  // A jump never stalls; the final ack releases the PC at the edge that delivers.
  always_comb begin
    stall_req = DISABLE;
    if (rst && !jump_enable) begin
      if (state_q == IF_IDLE) stall_req = !hit;
      else                    stall_req = !last_ack;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte-memory model acking on the slave port,
// scoreboard of expected {pc, inst} pushed per fetch and popped on delivery.
module tb_if_fetch;
  import if_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc_i;
  logic        jump_enable;
  logic        id_stall;
  logic        stall_req;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        ack_en;
  logic        ack_rand;

  int          tests_run    = 0;
  int          tests_failed = 0;
  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  logic [31:0] last_pc;
  logic [31:0] last_inst;

  if_fetch_if mif ();

  if_fetch #(.ICACHE_LINES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .pc_i        (pc_i),
    .jump_enable (jump_enable),
    .id_stall    (id_stall),
    .mem         (mif),
    .stall_req   (stall_req),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h00;
      32'h3: return 8'h00;
      default: return (a[7:0] * 8'd7 + a[15:8]) ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] b;
    b = {pc[31:2], 2'b00};
    return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
  endfunction

  // Memory controller model: accepts whenever requested and enabled.
  assign mif.mem_ack   = mif.mem_req && rdy && ack_en;
  assign mif.mem_rdata = mem_byte(mif.mem_addr);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_fetch(input logic [31:0] pc);
    exp_t e;
    pc_i   = pc;
    e.pc   = pc;
    e.inst = mem_word(pc);
    exp_q.push_back(e);
    addr_log.delete();
  endtask

  // Runs until the DUT drops stall_req, then checks the delivery at the next edge.
  task automatic run_until_done(output int stall_cycles, output int req_cycles);
    bit   done;
    exp_t e;
    stall_cycles = 0;
    req_cycles   = 0;
    done         = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ack_en = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (mif.mem_req === 1'b1) req_cycles++;
      if (mif.mem_ack === 1'b1) addr_log.push_back(mif.mem_addr);
      if (stall_req === 1'b0) begin
        done = 1'b1;
        break;
      end
      stall_cycles++;
      tick();
    end
    ack_en = 1'b1;
    tests_run++;
    if (!done) begin
      $display("FAIL fetch_timeout pc=%h: stall_req still high after 60 cycles", pc_i);
      tests_failed++;
    end else if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty: delivery with no expected entry, pc=%h", pc_i);
      tests_failed++;
      tick();
    end else begin
      e = exp_q.pop_front();
      tick();
      #1;
      if ({if_valid, if_pc, if_inst} !== {1'b1, e.pc, e.inst}) begin
        $display("FAIL deliver pc=%h: got valid=%b pc=%h inst=%h, want valid=1 pc=%h inst=%h",
                 e.pc, if_valid, if_pc, if_inst, e.pc, e.inst);
        tests_failed++;
      end
      last_pc   = e.pc;
      last_inst = e.inst;
    end
  endtask

  task automatic wait_ack_addr(input logic [31:0] a, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mif.mem_ack === 1'b1 && mif.mem_addr === a) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!found) begin
      $display("FAIL %s_wait: no ack at addr %h within 40 cycles, mem_addr=%h", name, a, mif.mem_addr);
      tests_failed++;
    end
  endtask

  task automatic check_stalls(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      $display("FAIL %s_stall_cycles: got %0d want %0d", name, got, want);
      tests_failed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; pc_i = 32'h0; jump_enable = 1'b0; id_stall = 1'b0;
    ack_en = 1'b1; ack_rand = 1'b0;
    repeat (3) tick();
    #1;
    tests_run += 4;
    if (if_valid !== 1'b0) begin $display("FAIL reset_if_valid: got %b want 0", if_valid); tests_failed++; end
    if ({if_pc, if_inst} !== 64'h0) begin $display("FAIL reset_if_pc_inst: got %h/%h want 0/0", if_pc, if_inst); tests_failed++; end
    if ({mif.mem_req, mif.mem_addr} !== 33'h0) begin $display("FAIL reset_mem: got req=%b addr=%h want 0/0", mif.mem_req, mif.mem_addr); tests_failed++; end
    if (stall_req !== 1'b0) begin $display("FAIL reset_stall_req: got %b want 0", stall_req); tests_failed++; end
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int  s, r;
    bit  ok;
    start_fetch(32'h0);
    run_until_done(s, r);
    check_stalls("cold_miss", s, 4);
    ok = (addr_log.size() == 4);
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== 32'(i)) ok = 1'b0;
    tests_run++;
    if (!ok) begin
      $display("FAIL cold_miss_addr_seq: got %0d acks first=%h, want 4 acks at 0..3",
               addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 32'hx);
      tests_failed++;
    end
  endtask

  task automatic test_hit();
    int s, r;
    start_fetch(32'h0);
    run_until_done(s, r);
    check_stalls("hit", s, 0);
    tests_run++;
    if (r !== 0 || mif.mem_req !== 1'b0) begin
      $display("FAIL hit_mem_req: got %0d request cycles, mem_req=%b, want 0/0", r, mif.mem_req);
      tests_failed++;
    end
  endtask

  task automatic test_conflict();
    int s, r;
    start_fetch(32'h100);
    run_until_done(s, r);
    check_stalls("conflict_100", s, 4);
    start_fetch(32'h0);
    run_until_done(s, r);
    check_stalls("conflict_000", s, 4);
    tests_run++;
    if (addr_log.size() !== 4) begin
      $display("FAIL conflict_refetch_acks: got %0d want 4", addr_log.size());
      tests_failed++;
    end
  endtask

  task automatic test_jump();
    int s, r;
    pc_i = 32'h200;
    wait_ack_addr(32'h202, "jump");
    jump_enable = 1'b1;
    #1;
    tests_run++;
    if (stall_req !== 1'b0) begin $display("FAIL jump_stall_req: got %b want 0", stall_req); tests_failed++; end
    tick();
    jump_enable = 1'b0;
    pc_i = 32'h0;
    #1;
    tests_run++;
    if ({mif.mem_req, if_valid} !== 2'b00) begin
      $display("FAIL jump_bubble: got mem_req=%b if_valid=%b want 0/0", mif.mem_req, if_valid);
      tests_failed++;
    end
    start_fetch(32'h0);
    run_until_done(s, r);
    check_stalls("jump_target_hit", s, 0);
    start_fetch(32'h200);
    run_until_done(s, r);
    check_stalls("jump_no_partial", s, 4);
  endtask

  task automatic test_rdy_freeze();
    int s, r;
    start_fetch(32'h310);
    wait_ack_addr(32'h311, "rdy");
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests_run++;
      if ({mif.mem_req, mif.mem_addr, if_valid, if_pc, if_inst} !== {1'b1, 32'h311, 1'b1, last_pc, last_inst}) begin
        $display("FAIL rdy_freeze_%0d: got req=%b addr=%h valid=%b pc=%h inst=%h, want 1/00000311/1/%h/%h",
                 i, mif.mem_req, mif.mem_addr, if_valid, if_pc, if_inst, last_pc, last_inst);
        tests_failed++;
      end
    end
    rdy = 1'b1;
    run_until_done(s, r);
  endtask

  task automatic test_id_stall();
    int s, r;
    bit found;
    id_stall = 1'b1;
    start_fetch(32'h420);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall_req === 1'b0) begin found = 1'b1; break; end
      tick();
    end
    tests_run++;
    if (!found) begin $display("FAIL id_stall_wait: stall_req never dropped"); tests_failed++; end
    tick();
    #1;
    tests_run++;
    if ({if_valid, if_pc, if_inst, mif.mem_req} !== {1'b1, last_pc, last_inst, 1'b0}) begin
      $display("FAIL id_stall_hold: got valid=%b pc=%h inst=%h req=%b, want 1/%h/%h/0",
               if_valid, if_pc, if_inst, mif.mem_req, last_pc, last_inst);
      tests_failed++;
    end
    id_stall = 1'b0;
    run_until_done(s, r);
    check_stalls("id_stall_then_hit", s, 0);
  endtask

  task automatic test_reset_mid_fetch();
    int s, r;
    pc_i = 32'h530;
    wait_ack_addr(32'h531, "rst");
    rst = 1'b0;
    tick();
    #1;
    tests_run++;
    if ({if_valid, if_pc, if_inst, mif.mem_req, mif.mem_addr, stall_req} !== 99'h0) begin
      $display("FAIL rst_mid_outputs: got valid=%b pc=%h inst=%h req=%b addr=%h stall=%b, want all 0",
               if_valid, if_pc, if_inst, mif.mem_req, mif.mem_addr, stall_req);
      tests_failed++;
    end
    rst = 1'b1;
    start_fetch(32'h420);
    run_until_done(s, r);
    check_stalls("rst_clears_lines", s, 4);
    start_fetch(32'h530);
    run_until_done(s, r);
    check_stalls("rst_no_partial", s, 4);
  endtask

  task automatic test_back_to_back();
    int s, r;
    ack_rand = 1'b1;
    start_fetch(32'h640);
    run_until_done(s, r);
    ack_rand = 1'b0;
    start_fetch(32'h640);
    run_until_done(s, r);
    check_stalls("b2b_hit_640", s, 0);
    start_fetch(32'h420);
    run_until_done(s, r);
    check_stalls("b2b_hit_420", s, 0);
    start_fetch(32'h310);
    run_until_done(s, r);
    check_stalls("b2b_miss_310", s, 4);
  endtask

  initial begin
    last_pc   = 32'h0;
    last_inst = 32'h0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_jump();
    test_rdy_freeze();
    test_id_stall();
    test_reset_mid_fetch();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: %0d entries never delivered, want 0", exp_q.size());
      tests_failed++;
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage sitting directly downstream of the PC register and upstream of the IF/ID pipeline register. Each cycle it takes the current PC and looks it up in a small direct-mapped instruction cache. On a miss it assembles the 32-bit instruction from four byte reads through the memory controller, refills the cache, and presents `{pc, inst}` to IF/ID. It raises a stall request while the instruction is not available, and abandons in-flight work on a jump redirect.

## Interface
- `ICACHE_LINES`, default 64: number of cache entries, one instruction each; must be a power of two, at least 2.
- `clk`  input  1: system clock.
- `rst`  input  1: synchronous, active-low reset; 0 = reset.
- `rdy`  input  1: global ready; when 0 every register holds.
- `pc_i`  input  32: current PC from the PC register; word-aligned.
- `jump_enable`  input  1: redirect this cycle; kills any fetch in progress.
- `id_stall`  input  1: downstream stall; when 1, the output register holds.
- `mem_req`  output  1: byte read request, held until acked.
- `mem_addr`  output  32: byte address of the current request.
- `mem_ack`  input  1: the controller accepted `mem_addr`; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  input  8: returned byte.
- `stall_req`  output  1: IF cannot deliver this cycle; feeds the stall controller.
- `if_valid`  output  1: `if_pc` and `if_inst` hold a real instruction.
- `if_pc`  output  32: PC of the delivered instruction.
- `if_inst`  output  32: delivered instruction.

## Operation
- Cache addressing:
  - index = `pc_i[IDX+1:2]`, where IDX = log2(`ICACHE_LINES`).
  - tag = `pc_i[31:IDX+2]`.
  - One valid bit per line.
  - `pc_i[1:0]` is ignored.
- Hit = line valid and tag match; it is combinational on `pc_i`.
- State machine has two states, IDLE and FETCH, plus a 2-bit byte counter `bcnt`.
- **IDLE, hit:**
  - `stall_req` = 0.
  - At the clock edge, if `id_stall` = 0: `if_valid` ← 1, `if_pc` ← `pc_i`, `if_inst` ← cached word.
- **IDLE, miss:**
  - `stall_req` = 1.
  - Go to FETCH with `bcnt` = 0 and `mem_addr` = `{pc_i[31:2], 2'b00}`.
  - `mem_req` rises in the following cycle.
- **FETCH:**
  - `mem_req` = 1 and `mem_addr` = base + `bcnt`.
  - On `mem_ack`, byte `bcnt` is stored at `inst[8*bcnt+7 : 8*bcnt]` (little-endian), and `bcnt` and `mem_addr` increment.
  - `stall_req` = 1, except in the cycle of the ack with `bcnt` = 3, where it is 0.
- **FETCH, ack with `bcnt` = 3:**
  - The line is written (valid ← 1, tag, data) and the state returns to IDLE.
  - If `id_stall` = 0, the output register loads the assembled word.
  - If `id_stall` = 1, the output register holds; the next lookup then hits.
- **`jump_enable` = 1, any state:**
  - Go to IDLE; the partial word is discarded and there is no cache write.
  - `mem_req` ← 0 at the next edge.
  - If `id_stall` = 0, `if_valid` ← 0 at that edge.
  - `stall_req` = 0 in that cycle.
- **Jump and ack in the same cycle:** the jump wins and the byte is discarded. Reads are side-effect free, so withdrawing a request is legal.
- **`rdy` = 0:** no register, cache, or state changes; outputs hold their values.
- **Reset:**
  - `if_valid` = 0, `if_pc` = 0, `if_inst` = 0, `mem_req` = 0, `mem_addr` = 0, `stall_req` = 0.
  - State = IDLE, `bcnt` = 0.
  - All cache valid bits = 0.
  - Reset during FETCH aborts with no cache write.

## Timing
- Hit: `stall_req` stays low; the instruction is at IF/ID one edge after `pc_i` is presented.
- Miss, best case (ack every cycle while requested):
  - 1 cycle to leave IDLE, then 4 ack cycles.
  - The instruction appears at the edge of the 4th ack.
  - The PC register advances at that same edge, because `stall_req` is 0 in that cycle.
- `mem_req`, `mem_addr`, and all `if_*` outputs are registered.
- `stall_req` is combinational from state, hit, and `mem_ack`.
- Redirect costs one bubble: `if_valid` = 0 for the cycle after the jump.

## Structure
- Shared package / `config.v`:
  - `AddrBus`, `InstBus`, `Enable`/`Disable`, `ZeroWord`.
  - New: `ByteBus` [7:0], `ICacheLines`, `ICacheIdxW`.
  - FSM state encodings `IF_IDLE` and `IF_FETCH`.
- Sub-module `icache`:
  - Direct-mapped arrays for valid, tag, and data.
  - Combinational read of hit/data.
  - Synchronous write port.
  - Synchronous clear of the valid bits on reset.
- `if_fetch` owns the FSM, byte assembly, and the output register.

## Test plan
- Cold miss: after reset, `pc_i` = 0x0 and memory bytes 0x13, 0x05, 0x00, 0x00, each acked immediately.
  - `mem_addr` steps 0x0 to 0x3.
  - `if_inst` = 0x00000513, `if_pc` = 0x0, `if_valid` = 1 at the 4th-ack edge.
  - `stall_req` is high for exactly 4 cycles.
- Re-fetch of 0x0 after the cold miss: hit, `stall_req` = 0, `mem_req` never rises, and `if_inst` = 0x00000513 one edge later.
- Conflict with `ICACHE_LINES` = 64: fetch 0x000, then 0x100 (same index, different tag), then 0x000 again.
  - All three are misses.
  - The final word is refetched from memory.
- Jump during FETCH: `jump_enable` asserted together with the ack of byte 2.
  - `mem_req` is 0 next cycle and `if_valid` = 0.
  - A later access to the same PC misses (no partial line written).
- Flow control, two checks:
  - `rdy` = 0 for 3 cycles mid-FETCH: `bcnt`, `mem_addr`, and the outputs are frozen, and the fetch then resumes to the correct word.
  - `id_stall` = 1 on the completion cycle: outputs hold the old instruction, and the next cycle hits and delivers.
- Reset: `rst` = 0 during byte 1.
  - All outputs return to their reset values.
  - All lines are invalid; a subsequent fetch of the same PC misses.
